// File: rtl/hc4_prog_loader.sv
// hc4_prog_loader: boot-time program loader for the hc4 core.
// Accepts a framed byte stream (A5, LEN_H, LEN_L, N data bytes [, CSUM]) on a
// valid/ready interface, writes the data bytes into the 4096x8 program memory
// and holds the core in reset until a complete, valid frame has been loaded.
// Optional feature macro: HC4_LOADER_CSUM_EN (adds the trailing checksum byte
// and its check; without it the Nth data byte completes the frame).
// ADDR_W must stay 12 so the frame length field covers the whole memory.

module hc4_prog_loader #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [ADDR_W-1:0] pm_addr,
   output logic [DATA_W-1:0] pm_wdata,
   output logic              pm_we,
   output logic              cpu_nReset,
   output logic              load_busy,
   output logic              load_done,
   output logic              load_err
);

   typedef enum logic [2:0] {
      ST_SYNC = 3'd0,
      ST_LENH = 3'd1,
      ST_LENL = 3'd2,
      ST_DATA = 3'd3,
`ifdef HC4_LOADER_CSUM_EN
      ST_CSUM = 3'd4,
`endif
      ST_DONE = 3'd5,
      ST_ERR  = 3'd6
   } state_t;

`ifdef HC4_LOADER_CSUM_EN
   // Running 8-bit additive checksum: a frame is good when sum + CSUM wraps to zero.
   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      csum_add = acc + b;
   endfunction
`endif

   state_t            state_q, state_d;
   logic [3:0]        lenh_q, lenh_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [12:0]       rem_q, rem_d;       // bytes still to write; 13 bits so N=4096 fits
`ifdef HC4_LOADER_CSUM_EN
   logic [7:0]        sum_q, sum_d;
`endif
   logic [ADDR_W-1:0] pm_addr_q, addr_d;
   logic [DATA_W-1:0] pm_wdata_q, wdata_d;
   logic              pm_we_q, we_d;
   logic              rx_ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              cpu_nreset_q;
   logic              accept_s;
   logic [11:0]       len_s;

   assign accept_s = rx_valid && rx_ready_q;
   assign len_s    = {lenh_q, rx_data[7:0]};

   // Next-state, write-port and status decode for one accepted byte.
   always_comb begin
      state_d = state_q;
      lenh_d  = lenh_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
`ifdef HC4_LOADER_CSUM_EN
      sum_d   = sum_q;
`endif
      addr_d  = pm_addr_q;
      wdata_d = pm_wdata_q;
      we_d    = 1'b0;
      if (accept_s) begin
         case (state_q)
            ST_SYNC: begin
               if (rx_data == 8'hA5) begin
                  state_d = ST_LENH;
               end else begin
                  state_d = ST_SYNC;
               end
            end
            ST_LENH: begin
               if (rx_data[7:4] != 4'd0) begin
                  state_d = ST_ERR;
               end else begin
                  lenh_d  = rx_data[3:0];
                  state_d = ST_LENL;
               end
            end
            ST_LENL: begin
               cnt_d   = {ADDR_W{1'b0}};
               // A zero length field encodes a full 4096-byte image.
               rem_d   = (len_s == 12'd0) ? 13'h1000 : {1'b0, len_s};
`ifdef HC4_LOADER_CSUM_EN
               sum_d   = 8'd0;
`endif
               state_d = ST_DATA;
            end
            ST_DATA: begin
               we_d    = 1'b1;
               addr_d  = cnt_q;
               wdata_d = rx_data;
               cnt_d   = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               rem_d   = rem_q - 13'd1;
`ifdef HC4_LOADER_CSUM_EN
               sum_d   = csum_add(sum_q, rx_data[7:0]);
`endif
               if (rem_q == 13'd1) begin
`ifdef HC4_LOADER_CSUM_EN
                  state_d = ST_CSUM;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  state_d = ST_DATA;
               end
            end
`ifdef HC4_LOADER_CSUM_EN
            ST_CSUM: begin
               if (csum_add(sum_q, rx_data[7:0]) == 8'd0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ERR;
               end
            end
`endif
            ST_DONE: begin
               state_d = ST_DONE;
            end
            ST_ERR: begin
               if (rx_data == 8'hA5) begin
                  state_d = ST_LENH;
               end else begin
                  state_d = ST_ERR;
               end
            end
            default: begin
               state_d = ST_SYNC;
            end
         endcase
      end else begin
         state_d = state_q;
      end

      // Status outputs are a pure function of the state being entered.
      ready_d = 1'b1;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_d)
         ST_LENH, ST_LENL, ST_DATA: busy_d = 1'b1;
`ifdef HC4_LOADER_CSUM_EN
         ST_CSUM: busy_d = 1'b1;
`endif
         ST_DONE: begin
            ready_d = 1'b0;
            done_d  = 1'b1;
         end
         ST_ERR:  err_d = 1'b1;
         default: busy_d = 1'b0;
      endcase
   end

   // Frame state machine with all outputs registered.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= ST_SYNC;
         lenh_q       <= 4'd0;
         cnt_q        <= {ADDR_W{1'b0}};
         rem_q        <= 13'd0;
`ifdef HC4_LOADER_CSUM_EN
         sum_q        <= 8'd0;
`endif
         pm_addr_q    <= {ADDR_W{1'b0}};
         pm_wdata_q   <= {DATA_W{1'b0}};
         pm_we_q      <= 1'b0;
         rx_ready_q   <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         cpu_nreset_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         lenh_q       <= lenh_d;
         cnt_q        <= cnt_d;
         rem_q        <= rem_d;
`ifdef HC4_LOADER_CSUM_EN
         sum_q        <= sum_d;
`endif
         pm_addr_q    <= addr_d;
         pm_wdata_q   <= wdata_d;
         pm_we_q      <= we_d;
         rx_ready_q   <= ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         cpu_nreset_q <= done_d;
      end
   end

   assign rx_ready   = rx_ready_q;
   assign pm_addr    = pm_addr_q;
   assign pm_wdata   = pm_wdata_q;
   assign pm_we      = pm_we_q;
   assign cpu_nReset = cpu_nreset_q;
   assign load_busy  = busy_q;
   assign load_done  = done_q;
   assign load_err   = err_q;

endmodule

// File: tb/tb_hc4_prog_loader.sv
// Self-checking bench for hc4_prog_loader. A frame-position model predicts
// every output each cycle; directed frames plus randomized frames/gaps.
`timescale 1ns/1ps

module tb_hc4_prog_loader;

   logic        clk = 1'b0;
   logic        Reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [11:0] pm_addr;
   logic [7:0]  pm_wdata;
   logic        pm_we;
   logic        cpu_nReset;
   logic        load_busy;
   logic        load_done;
   logic        load_err;

   hc4_prog_loader #(.ADDR_W(12), .DATA_W(8)) dut (
      .clk(clk), .Reset(Reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .pm_addr(pm_addr), .pm_wdata(pm_wdata), .pm_we(pm_we),
      .cpu_nReset(cpu_nReset), .load_busy(load_busy), .load_done(load_done),
      .load_err(load_err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Model: position inside the current frame (-1 = hunting for sync).
   int          m_pos, m_lenh, m_n, m_sum;
   logic        exp_ready, exp_we, exp_nreset, exp_busy, exp_done, exp_err;
   logic [11:0] exp_addr;
   logic [7:0]  exp_wdata;

   // What the DUT actually wrote.
   logic [7:0]  dmem [4096];
   int          hits [4096];
   int          wr_count;
   logic [7:0]  payload [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
      end
   endtask

   task automatic model_reset();
      m_pos = -1; m_lenh = 0; m_n = 0; m_sum = 0;
      exp_ready = 1'b1; exp_we = 1'b0; exp_nreset = 1'b0;
      exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
      exp_addr = 12'd0; exp_wdata = 8'd0;
   endtask

   task automatic model_finish();
      exp_done = 1'b1; exp_nreset = 1'b1; exp_ready = 1'b0;
   endtask

   task automatic model_accept(input logic [7:0] b);
      if (m_pos < 0) begin
         if (b == 8'hA5) begin m_pos = 0; exp_err = 1'b0; end
      end else if (m_pos == 0) begin
         if (b >= 8'h10) begin exp_err = 1'b1; m_pos = -1; end
         else begin m_lenh = int'(b); m_pos = 1; end
      end else if (m_pos == 1) begin
         m_n = m_lenh * 256 + int'(b);
         if (m_n == 0) m_n = 4096;
         m_sum = 0; m_pos = 2;
      end else if (m_pos < 2 + m_n) begin
         exp_we = 1'b1; exp_addr = 12'(m_pos - 2); exp_wdata = b;
         m_sum = (m_sum + int'(b)) % 256;
         m_pos++;
`ifndef HC4_LOADER_CSUM_EN
         if (m_pos == 2 + m_n) model_finish();
`endif
      end else begin
         if ((m_sum + int'(b)) % 256 == 0) model_finish();
         else begin exp_err = 1'b1; m_pos = -1; end
      end
      exp_busy = (m_pos >= 0) && !exp_done;
   endtask

   task automatic check_all();
      chk("rx_ready", 32'(rx_ready), 32'(exp_ready));
      chk("pm_we", 32'(pm_we), 32'(exp_we));
      chk("pm_addr", 32'(pm_addr), 32'(exp_addr));
      chk("pm_wdata", 32'(pm_wdata), 32'(exp_wdata));
      chk("cpu_nReset", 32'(cpu_nReset), 32'(exp_nreset));
      chk("load_busy", 32'(load_busy), 32'(exp_busy));
      chk("load_done", 32'(load_done), 32'(exp_done));
      chk("load_err", 32'(load_err), 32'(exp_err));
   endtask

   // One clock: drive, let the edge happen, advance the model, compare.
   task automatic cycle(input logic v, input logic [7:0] d);
      logic pre_ready;
      @(negedge clk);
      rx_valid = v; rx_data = d;
      @(posedge clk);
      pre_ready = exp_ready;
      exp_we = 1'b0;
      if (v && pre_ready) model_accept(d);
      #1;
      check_all();
      if (pm_we === 1'b1) begin
         dmem[pm_addr] = pm_wdata;
         hits[pm_addr]++;
         wr_count++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom));
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      if (gaps) idle($urandom_range(0, 2));
      cycle(1'b1, b);
   endtask

   // Sends A5, LEN_H (with hinib in the top nibble), LEN_L, payload[, CSUM+cs_delta].
   // Without the checksum build, a nonzero cs_delta becomes a stray trailing byte.
   task automatic send_frame(input int hinib, input int cs_delta, input bit gaps);
      int n = payload.size();
      logic [11:0] lenv = 12'(n);
      logic [7:0] lh, ll, cs;
      int s = 0;
      lh = {4'(hinib), lenv[11:8]};
      ll = lenv[7:0];
      send_byte(8'hA5, gaps);
      send_byte(lh, gaps);
      if (hinib != 0) return;
      send_byte(ll, gaps);
      foreach (payload[i]) begin
         send_byte(payload[i], gaps);
         s += int'(payload[i]);
      end
      cs = 8'((256 - (s % 256)) % 256 + cs_delta);
`ifdef HC4_LOADER_CSUM_EN
      send_byte(cs, gaps);
`else
      if (cs_delta != 0) send_byte(cs, gaps);
`endif
   endtask

   // Reset asserted between edges: outputs must clear before any clock.
   task automatic do_reset();
      @(negedge clk);
      rx_valid = 1'b0;
      #2 Reset = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk); #1;
      check_all();
      @(negedge clk);
      Reset = 1'b0;
      wr_count = 0;
      for (int i = 0; i < 4096; i++) hits[i] = 0;
   endtask

   initial begin
      int full;
      Reset = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; wr_count = 0;
      for (int i = 0; i < 4096; i++) begin hits[i] = 0; dmem[i] = 8'd0; end
      model_reset();
      #1 check_all();
      @(negedge clk) Reset = 1'b0;
      idle(2);

      // Basic three-byte frame.
      payload = '{8'h11, 8'h22, 8'h33};
      send_frame(0, 0, 1'b0);
      idle(2);
      chk("t1_mem0", 32'(dmem[0]), 32'h11);
      chk("t1_mem1", 32'(dmem[1]), 32'h22);
      chk("t1_mem2", 32'(dmem[2]), 32'h33);
      chk("t1_writes", 32'(wr_count), 32'd3);
      chk("t1_done", 32'(load_done), 32'd1);
      chk("t1_nreset", 32'(cpu_nReset), 32'd1);
      chk("t1_ready", 32'(rx_ready), 32'd0);

`ifdef HC4_LOADER_CSUM_EN
      // Bad checksum, then resync from the error state.
      do_reset();
      send_frame(0, 8'h66, 1'b1);
      idle(2);
      chk("t2_err", 32'(load_err), 32'd1);
      chk("t2_nreset", 32'(cpu_nReset), 32'd0);
      send_frame(0, 0, 1'b1);
      idle(2);
      chk("t2_err_clr", 32'(load_err), 32'd0);
      chk("t2_done", 32'(load_done), 32'd1);
`endif

      // Garbage before sync.
      do_reset();
      send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'h5A, 1'b0);
      payload = '{8'h7E};
      send_frame(0, 0, 1'b1);
      idle(2);
      chk("t3_mem0", 32'(dmem[0]), 32'h7E);
      chk("t3_writes", 32'(wr_count), 32'd1);
      chk("t3_done", 32'(load_done), 32'd1);

      // Full 4096-byte image, back-to-back, then a stray byte.
      do_reset();
      payload.delete();
      for (int i = 0; i < 4096; i++) payload.push_back(8'(i));
      send_frame(0, 0, 1'b0);
      send_byte(8'h55, 1'b0);
      idle(2);
      full = 0;
      for (int i = 0; i < 4096; i++) if (hits[i] == 1 && dmem[i] == 8'(i)) full++;
      chk("t4_once_each", 32'(full), 32'd4096);
      chk("t4_writes", 32'(wr_count), 32'd4096);
      chk("t4_done", 32'(load_done), 32'd1);

      // Length high nibble error, then recovery.
      do_reset();
      payload = '{8'h01, 8'h02};
      send_frame(1, 0, 1'b0);
      idle(1);
      chk("t5_err", 32'(load_err), 32'd1);
      chk("t5_writes", 32'(wr_count), 32'd0);
      chk("t5_busy", 32'(load_busy), 32'd0);
      send_byte(8'h3C, 1'b1);
      payload = '{8'h0A, 8'h0B, 8'h0C};
      send_frame(0, 0, 1'b1);
      idle(2);
      chk("t5_done", 32'(load_done), 32'd1);

      // Reset mid-frame, then a complete frame.
      do_reset();
      send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
      send_byte(8'hD1, 1'b1); send_byte(8'hD2, 1'b1);
      do_reset();
      payload = '{8'h91, 8'h92, 8'h93, 8'h94, 8'h95};
      send_frame(0, 0, 1'b1);
      idle(2);
      chk("t6_mem4", 32'(dmem[4]), 32'h95);
      chk("t6_done", 32'(load_done), 32'd1);

      // Randomized frames with gaps, garbage, and injected errors.
      for (int f = 0; f < 25; f++) begin
         int hn, dl;
         do_reset();
         repeat ($urandom_range(0, 3)) send_byte(8'($urandom), 1'b1);
         payload.delete();
         repeat ($urandom_range(1, 24)) payload.push_back(8'($urandom));
         hn = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : 0;
         dl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : 0;
         send_frame(hn, dl, 1'b1);
         idle(2);
         if (exp_err) begin
            send_frame(0, 0, 1'b1);
            idle(2);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
